// File: rtl/instruction_loader_if.sv
// Boot-loader bus bundle: UART byte stream in, instruction-memory write port
// and CPU fetch handover out.
interface instruction_loader_if #(
    parameter int ADDR_WIDTH = 16
);
    logic                  rx_valid;
    logic [7:0]            rx_data;
    logic                  reload;
    logic [ADDR_WIDTH-1:0] cpu_address;
    logic                  mem_write_enable;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [31:0]           mem_write_data;
    logic                  load_done;
    logic                  cpu_stall;
    logic                  load_error;

    modport slave (
        input  rx_valid, rx_data, reload, cpu_address,
        output mem_write_enable, mem_address, mem_write_data,
               load_done, cpu_stall, load_error
    );

    modport master (
        output rx_valid, rx_data, reload, cpu_address,
        input  mem_write_enable, mem_address, mem_write_data,
               load_done, cpu_stall, load_error
    );
endinterface

// File: rtl/instruction_loader.sv
// Boot-time instruction loader: packs big-endian UART bytes into words, writes
// them to consecutive addresses, then hands the memory address port to the CPU.
//
// state  | meaning
// HEADER | collecting the 4-byte word count N
// LOAD   | packing program words, one write per completed word
// DONE   | program written; CPU owns mem_address, stall released
// ERROR  | N exceeded MEM_SIZE; waits for reload or reset
module instruction_loader #(
    parameter int MEM_SIZE   = 20000,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    instruction_loader_if.slave  bus
);

    typedef enum logic [1:0] {HEADER, LOAD, DONE, ERROR} state_t;

    state_t                state;
    state_t                state_next;
    logic [1:0]            byte_cnt;
    logic [23:0]           shift_reg;
    logic [31:0]           remaining;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic                  pending;
    logic [31:0]           wr_data;

    logic                  byte_in;
    logic                  word_end;
    logic                  write_now;
    logic [31:0]           word_in;

    // A byte arriving with reload is dropped; bytes are ignored once loading ended.
    assign byte_in   = bus.rx_valid && !bus.reload && (state == HEADER || state == LOAD);
    assign word_in   = {shift_reg, bus.rx_data};
    assign word_end  = byte_in && (byte_cnt == 2'd3);
    assign write_now = pending && !bus.reload;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= HEADER;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (bus.reload) begin
            state_next = HEADER;
        end else begin
            case (state)
                HEADER: if (word_end) begin
                    if (word_in == 32'd0)                 state_next = DONE;
                    else if (word_in > 32'(MEM_SIZE))     state_next = ERROR;
                    else                                  state_next = LOAD;
                end
                LOAD:   if (write_now && remaining == 32'd1) state_next = DONE;
                default: state_next = state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt  <= 2'd0;
            shift_reg <= 24'd0;
            remaining <= 32'd0;
            wr_ptr    <= '0;
            pending   <= 1'b0;
            wr_data   <= 32'd0;
        end else if (bus.reload) begin
            byte_cnt  <= 2'd0;
            shift_reg <= 24'd0;
            wr_ptr    <= '0;
            pending   <= 1'b0;
        end else begin
            if (byte_in) begin
                byte_cnt  <= byte_cnt + 2'd1;
                shift_reg <= word_in[23:0];
            end
            if (state == HEADER && word_end) remaining <= word_in;
            if (state == LOAD && word_end) begin
                pending <= 1'b1;
                wr_data <= word_in;
            end
            // A new word needs 4 cycles, so a write never overlaps the next word_end.
            if (write_now) begin
                pending   <= 1'b0;
                wr_ptr    <= wr_ptr + 1'b1;
                remaining <= remaining - 32'd1;
            end
        end
    end

    assign bus.mem_write_enable = write_now;
    assign bus.mem_write_data   = wr_data;
    assign bus.mem_address      = (state == DONE) ? bus.cpu_address : wr_ptr;
    assign bus.load_done        = (state == DONE);
    assign bus.cpu_stall        = (state != DONE);
    assign bus.load_error       = (state == ERROR);

endmodule

// File: tb/tb_instruction_loader.sv
// Directed and randomized bench for instruction_loader against a stream-level
// model that derives the expected write list straight from the byte stream.
module tb_instruction_loader;

    localparam int MEM_SIZE   = 20000;
    localparam int ADDR_WIDTH = 16;

    logic clk;
    logic rst_n;

    instruction_loader_if #(.ADDR_WIDTH(ADDR_WIDTH)) bus ();

    instruction_loader #(.MEM_SIZE(MEM_SIZE), .ADDR_WIDTH(ADDR_WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_wr_cycle = -1;
    int done_cycle = -1;
    logic prev_done = 1'b0;

    logic [47:0] got_q[$];
    logic [47:0] exp_q[$];
    logic        exp_done;
    logic        exp_err;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.mem_write_enable === 1'b1) begin
            got_q.push_back({bus.mem_address, bus.mem_write_data});
            last_wr_cycle = cyc;
        end
        if (bus.load_done === 1'b1 && prev_done !== 1'b1) done_cycle = cyc;
        prev_done = bus.load_done;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Callers are always positioned 1 time unit after a rising edge.
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
    endtask

    task automatic send_stream(input logic [7:0] s[$], input int max_gap);
        foreach (s[i]) begin
            send_byte(s[i]);
            if (max_gap > 0) idle($urandom_range(0, max_gap));
        end
    endtask

    task automatic pulse_reload();
        bus.reload = 1'b1;
        @(posedge clk);
        #1;
        bus.reload = 1'b0;
    endtask

    // Reference: header gives N; words follow big-endian at addresses 0..N-1.
    task automatic model(input logic [7:0] s[$]);
        logic [31:0] n;
        exp_q.delete();
        n = {s[0], s[1], s[2], s[3]};
        exp_err  = (n > MEM_SIZE);
        exp_done = !exp_err && (s.size() >= 4 + 4 * int'(n));
        if (!exp_err) begin
            for (int i = 0; i < int'(n) && (4 + 4 * i + 3) < s.size(); i++)
                exp_q.push_back({16'(i), s[4+4*i], s[5+4*i], s[6+4*i], s[7+4*i]});
        end
    endtask

    task automatic check_run(input string tag);
        idle(3);
        chk({tag, "_nwrites"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("%s_write%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
        chk({tag, "_done"},  64'(bus.load_done),  64'(exp_done));
        chk({tag, "_error"}, 64'(bus.load_error), 64'(exp_err));
        chk({tag, "_stall"}, 64'(bus.cpu_stall),  64'(!exp_done));
    endtask

    initial begin
        logic [7:0] s[$];
        logic [31:0] n;
        logic [15:0] ca;

        rst_n           = 1'b0;
        bus.rx_valid    = 1'b0;
        bus.rx_data     = 8'h00;
        bus.reload      = 1'b0;
        bus.cpu_address = '0;
        #12;
        chk("rst_we",    64'(bus.mem_write_enable), 64'd0);
        chk("rst_wdata", 64'(bus.mem_write_data),   64'd0);
        chk("rst_done",  64'(bus.load_done),        64'd0);
        chk("rst_err",   64'(bus.load_error),       64'd0);
        chk("rst_stall", 64'(bus.cpu_stall),        64'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);

        // Two-word program, back-to-back bytes.
        s = '{8'h00, 8'h00, 8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF,
              8'h01, 8'h23, 8'h45, 8'h67};
        model(s);
        got_q.delete();
        send_stream(s, 0);
        check_run("n2");
        chk("n2_done_timing", 64'(done_cycle), 64'(last_wr_cycle + 1));

        // Empty program goes straight to DONE; CPU owns the address port.
        pulse_reload();
        got_q.delete();
        s = '{8'h00, 8'h00, 8'h00, 8'h00};
        model(s);
        send_stream(s, 0);
        check_run("n0");
        bus.cpu_address = 16'h0010;
        #1;
        chk("n0_cpu_addr", 64'(bus.mem_address), 64'h0010);

        // Oversized header: sticky error, later bytes ignored, reload clears.
        pulse_reload();
        got_q.delete();
        bus.cpu_address = 16'h1234;
        s = '{8'h00, 8'h00, 8'h4E, 8'h21, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        model(s);
        exp_q.delete();
        send_stream(s, 0);
        check_run("err");
        pulse_reload();
        chk("err_cleared", 64'(bus.load_error), 64'd0);
        chk("err_hdr_addr", 64'(bus.mem_address), 64'd0);

        // Three words on 12 consecutive cycles after the header.
        got_q.delete();
        s = '{8'h00, 8'h00, 8'h00, 8'h03, 8'h10, 8'h20, 8'h30, 8'h40,
              8'h50, 8'h60, 8'h70, 8'h80, 8'h90, 8'hA0, 8'hB0, 8'hC0};
        model(s);
        send_stream(s, 0);
        check_run("n3");

        // Reload after 1.5 words discards the partial word.
        pulse_reload();
        got_q.delete();
        s = '{8'h00, 8'h00, 8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23};
        send_stream(s, 0);
        idle(2);
        chk("mid_first_write", 64'(got_q.size()), 64'd1);
        pulse_reload();
        got_q.delete();
        s = '{8'h00, 8'h00, 8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        model(s);
        send_stream(s, 0);
        check_run("reload_n1");

        // Reload in the cycle a write is pending suppresses that write.
        pulse_reload();
        got_q.delete();
        s = '{8'h00, 8'h00, 8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78};
        send_stream(s, 0);
        pulse_reload();
        idle(2);
        chk("suppress_nwrites", 64'(got_q.size()), 64'd0);
        s = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        model(s);
        send_stream(s, 0);
        check_run("suppress_after");

        // Asynchronous reset between edges mid-LOAD.
        pulse_reload();
        got_q.delete();
        s = '{8'h00, 8'h00, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        send_stream(s, 0);
        chk("arst_pre_data", 64'(bus.mem_write_data), 64'h11223344);
        chk("arst_pre_addr", 64'(bus.mem_address), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_data", 64'(bus.mem_write_data), 64'd0);
        chk("arst_addr", 64'(bus.mem_address), 64'd0);
        chk("arst_done", 64'(bus.load_done), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        got_q.delete();
        s = '{8'h00, 8'h00, 8'h00, 8'h01, 8'hCA, 8'hFE, 8'hF0, 8'h0D};
        model(s);
        send_stream(s, 0);
        check_run("arst_fresh");

        // Randomized programs with random byte gaps; one oversized header.
        for (int it = 0; it < 8; it++) begin
            pulse_reload();
            got_q.delete();
            if (it == 3) n = 32'(MEM_SIZE + 1 + $urandom_range(0, 1000));
            else         n = 32'($urandom_range(1, 6));
            s = '{n[31:24], n[23:16], n[15:8], n[7:0]};
            for (int j = 0; j < (it == 3 ? 8 : 4 * int'(n)); j++)
                s.push_back(8'($urandom_range(0, 255)));
            model(s);
            send_stream(s, 2);
            check_run($sformatf("rnd%0d", it));
            if (exp_done) begin
                chk($sformatf("rnd%0d_done_timing", it), 64'(done_cycle), 64'(last_wr_cycle + 1));
                ca = 16'($urandom_range(0, 65535));
                bus.cpu_address = ca;
                #1;
                chk($sformatf("rnd%0d_cpu_addr", it), 64'(bus.mem_address), 64'(ca));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_loader.md
Name: instruction_loader

Overview:
Boot-time controller that owns the write side of the instruction memory. It receives a program as a byte stream from the UART receiver, packs four bytes per instruction word and writes the words to consecutive addresses. It then hands the memory address port to the CPU fetch stage, which stays stalled until loading completes. It sits between the UART receiver, the instruction memory and the fetch stage, and drives the memory's write_enable, address and write_data.

Parameters:
MEM_SIZE, 20000, number of instruction words in the instruction memory; the largest accepted program length.
ADDR_WIDTH, 16, width of memory and CPU addresses.

Ports:
clk  input  1  system clock; all state updates on its rising edge.
rst_n  input  1  asynchronous, active-low reset.
rx_valid  input  1  one-cycle strobe: rx_data holds a received byte.
rx_data  input  8  received byte.
reload  input  1  one-cycle pulse: discard the current program and restart loading.
cpu_address  input  ADDR_WIDTH  fetch address from the CPU.
mem_write_enable  output  1  write strobe to the instruction memory.
mem_address  output  ADDR_WIDTH  address to the instruction memory.
mem_write_data  output  32  word to write.
load_done  output  1  high once the program is fully written.
cpu_stall  output  1  holds the fetch stage; equals the inverse of load_done.
load_error  output  1  sticky flag: header length exceeds MEM_SIZE.

Behaviour:
- States: HEADER, LOAD, DONE, ERROR.
- Reset (asynchronous, while rst_n=0):
  - state=HEADER; byte counter=0; word counter=0; write pointer=0; shift register=0.
  - mem_write_enable=0, mem_write_data=0, load_done=0, load_error=0.
- Byte packing:
  - Big-endian: the first byte of each group of four becomes bits [31:24].
  - A 2-bit byte counter wraps 3->0 on every accepted byte.
  - rx_valid is ignored in DONE and ERROR.
- HEADER:
  - The first 4 bytes form the 32-bit word count N. Nothing is written to memory.
  - On the 4th byte: N=0 goes to DONE; N>MEM_SIZE goes to ERROR and sets load_error; otherwise go to LOAD with remaining=N.
- LOAD:
  - The 4th byte of each word is registered. In the next cycle, mem_write_enable=1 for exactly one cycle, mem_write_data=packed word and mem_address=write pointer.
  - The write pointer then increments and remaining decrements.
  - When the write of the last word occurs (remaining 1->0), go to DONE in the same cycle.
  - Back-to-back rx_valid on consecutive cycles is legal: 4 bytes take at least 4 cycles, so at most one write is ever pending.
- DONE:
  - load_done=1, cpu_stall=0, mem_write_enable=0.
  - mem_address is the combinational mux output cpu_address.
  - In all other states mem_address is the write pointer.
- ERROR:
  - load_done=0; cpu_stall=1; load_error stays 1.
  - Leaves only on reload or reset.
- reload:
  - From any state: next cycle state=HEADER; byte counter, write pointer and shift register are cleared; load_done=0; load_error=0.
  - Any partial word is discarded.
  - A reload coinciding with rx_valid drops that byte.
  - A reload coinciding with a pending write suppresses the write.
- Reset mid-load: identical to power-up; the memory contents are not cleared.
- Timing: memory reads stay synchronous (one cycle). The CPU's first fetch occurs no earlier than the cycle after load_done rises.

Test Plan:
- Header bytes 00 00 00 02, then DE AD BE EF 01 23 45 67 -> writes 0xDEADBEEF at address 0 and 0x01234567 at address 1, one cycle each. load_done rises the cycle of the second write +1; cpu_stall falls at the same time.
- Header 00 00 00 00 -> DONE directly after the 4th byte, with no write strobes. mem_address follows cpu_address (drive 0x0010, expect 0x0010).
- Header 00 00 4E 21 (20001) -> load_error=1, load_done=0, stays stalled; subsequent bytes cause no writes. A reload pulse clears load_error and returns to HEADER.
- Header N=3 with bytes on 12 consecutive cycles -> three writes, to addresses 0, 1 and 2, no write lost or duplicated.
- After 1.5 words of an N=2 load, pulse reload and resend a full N=1 stream AA BB CC DD -> single write 0xAABBCCDD at address 0.
- Assert rst_n=0 asynchronously between clock edges mid-LOAD -> outputs reset immediately without waiting for a clock edge; a fresh stream loads correctly from address 0.
